// File: rtl/gps_iq_player.sv
// -----------------------------------------------------------------------------
// gps_iq_player
//
// Replays a host-loaded block of packed I/Q sample words into the GPS
// correlator sample path, one word per sample strobe. It is the playback
// twin of the IQ capture buffer and is used to drive the acquisition and
// tracking chain with recorded data during bench and regression runs.
//
// Load side (host register interface):
//   ld_wr     - write strobe, one word per cycle, appended at address count
//   ld_clr    - empties the buffer (count <= 0); wins over a same-cycle ld_wr
//   din       - write data
//   count     - number of words held (0 .. 2^AW)
//   full      - count == 2^AW; further writes are dropped
//   Loading is frozen while a playback run is in progress.
//
// Play side (sample mux ahead of the GPS channels):
//   start     - begin a run from address 0 (ignored when the buffer is empty
//               or a run is already in progress)
//   stop      - abort the run; wins over a same-cycle start
//   loop_en   - level, looked at only when the last word is read: replay
//               from address 0 instead of finishing
//   sample_en - sample-rate strobe; each strobe in a run reads one word
//   dout      - played word, valid one cycle after its strobe, held between
//   dout_vld  - one-cycle qualifier for dout
//   busy      - high while a run is in progress
//   done      - one-cycle pulse alongside the last word of a non-looping pass
//   loops     - wraps completed in the current run, saturating at 0xFFFF
//
// Reset is asynchronous active-low. RAM contents survive reset.
// -----------------------------------------------------------------------------
module gps_iq_player #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_wr,
    input  logic          ld_clr,
    input  logic [DW-1:0] din,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          sample_en,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic [AW:0]   count,
    output logic [15:0]   loops
);

    // Counts and addresses are AW+1 bits wide so a full buffer (2^AW words)
    // is representable and its last address compares correctly.
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DW-1:0] mem [2**AW];

    logic [AW:0] raddr;
    logic [AW:0] last_addr;
    logic        running;
    logic        strobe;
    logic        at_last;
    logic        start_ok;
    logic        pass_end;
    logic        load_ok;
    logic        enter_run;

    // -------------------------------------------------------------------------
    // Qualifiers
    // -------------------------------------------------------------------------
    assign running   = (state == S_RUN);
    assign strobe    = running & sample_en;
    assign last_addr = count - ONE;
    assign at_last   = (raddr == last_addr);

    // A clear in the same cycle as start empties the buffer, so the start is
    // treated like a start on an empty buffer and ignored.
    assign start_ok  = start & ~stop & ~ld_clr & (count != '0);

    // The last word of a non-looping pass ends the run; an abort in the same
    // cycle takes precedence and suppresses done.
    assign pass_end  = strobe & at_last & ~loop_en & ~stop;

    assign load_ok   = ~running & ld_wr & ~ld_clr & ~full;
    assign full      = (count == DEPTH);
    assign enter_run = ~running & (state_nxt == S_RUN);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this combinational block
    // from inferring a latch on any path that does not change state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop)          state_nxt = S_IDLE;
                else if (pass_end) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (stop || ld_clr) state_nxt = S_IDLE;
                else if (start_ok)  state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        if (state == S_RUN) busy = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Sample RAM write port
    // -------------------------------------------------------------------------
    // NOTE: the RAM array has no reset so it maps onto block RAM; recorded data
    // therefore survives a reset and only count needs reloading.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[count[AW-1:0]] <= din;
        end
    end

    // -------------------------------------------------------------------------
    // Load count, play address, wrap counter and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            raddr    <= '0;
            loops    <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            done     <= 1'b0;
        end else begin
            // The read issued by a strobe lands in dout on the same edge, so
            // the word is presented exactly one cycle after its strobe; this
            // also covers a strobe that coincides with stop.
            dout_vld <= strobe;
            done     <= pass_end;
            if (strobe) begin
                dout <= mem[raddr[AW-1:0]];
            end

            if (!running) begin
                if (ld_clr) begin
                    count <= '0;
                end else if (load_ok) begin
                    count <= count + ONE;
                end
            end

            if (enter_run) begin
                raddr <= '0;
                loops <= '0;
            end else if (strobe) begin
                if (at_last) begin
                    raddr <= '0;
                    if (loop_en && (loops != 16'hFFFF)) begin
                        loops <= loops + 16'd1;
                    end
                end else begin
                    raddr <= raddr + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gps_iq_player.sv
// -----------------------------------------------------------------------------
// tb_gps_iq_player
//
// Directed sequence with random sample data. The reference model holds the
// loaded words in a queue; during a run the k-th strobe is expected to yield
// word (k mod n), a non-looping run ends with done on word n-1, and the wrap
// counter equals k / n for looping runs.
// -----------------------------------------------------------------------------
module tb_gps_iq_player;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          ld_wr;
    logic          ld_clr;
    logic [DW-1:0] din;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          sample_en;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   count;
    logic [15:0]   loops;

    gps_iq_player #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_wr     (ld_wr),
        .ld_clr    (ld_clr),
        .din       (din),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .sample_en (sample_en),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .count     (count),
        .loops     (loops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] mdl_buf[$];
    bit            mdl_run;
    bit            mdl_loop;
    int            mdl_k;
    int            mdl_n;
    logic [DW-1:0] mdl_dout;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_loops();
        int v;
        if (!mdl_loop || mdl_n == 0) return 0;
        v = mdl_k / mdl_n;
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".busy"},  busy,  mdl_run);
        check({tag, ".count"}, count, mdl_buf.size());
        check({tag, ".full"},  full,  mdl_buf.size() == DEPTH);
        check({tag, ".loops"}, loops, exp_loops());
    endtask

    // One host write; with clr set the same cycle also carries ld_clr.
    task automatic load(input logic [DW-1:0] d, input bit clr, input string tag);
        ld_wr  = 1'b1;
        ld_clr = clr;
        din    = d;
        step();
        ld_wr  = 1'b0;
        ld_clr = 1'b0;
        if (!mdl_run) begin
            if (clr)                          mdl_buf.delete();
            else if (mdl_buf.size() < DEPTH)  mdl_buf.push_back(d);
        end
        check_status(tag);
    endtask

    task automatic do_start(input bit stp, input string tag);
        start = 1'b1;
        stop  = stp;
        step();
        start = 1'b0;
        stop  = 1'b0;
        if (!mdl_run && !stp && mdl_buf.size() != 0) begin
            mdl_run  = 1'b1;
            mdl_k    = 0;
            mdl_n    = mdl_buf.size();
            mdl_loop = loop_en;
        end
        if (stp) mdl_run = 1'b0;
        check({tag, ".vld"}, dout_vld, 1'b0);
        check_status(tag);
    endtask

    // One cycle with optional strobe and optional stop.
    task automatic play_cycle(input bit se, input bit stp, input string tag);
        logic exp_vld;
        logic exp_done;
        exp_vld   = 1'b0;
        exp_done  = 1'b0;
        sample_en = se;
        stop      = stp;
        step();
        sample_en = 1'b0;
        stop      = 1'b0;
        if (se && mdl_run) begin
            exp_vld  = 1'b1;
            mdl_dout = mdl_buf[mdl_k % mdl_n];
            if ((mdl_k % mdl_n) == mdl_n - 1 && !mdl_loop && !stp) begin
                exp_done = 1'b1;
                mdl_run  = 1'b0;
            end
            mdl_k++;
        end
        if (stp) mdl_run = 1'b0;
        check({tag, ".vld"},  dout_vld, exp_vld);
        check({tag, ".done"}, done,     exp_done);
        check({tag, ".dout"}, dout,     mdl_dout);
        check_status(tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        mdl_run   = 1'b0;
        mdl_loop  = 1'b0;
        mdl_k     = 0;
        mdl_n     = 0;
        mdl_dout  = '0;
        rst_n     = 1'b0;
        ld_wr     = 1'b0;
        ld_clr    = 1'b0;
        din       = '0;
        start     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        sample_en = 1'b0;

        // Reset state
        #3;
        check("rst.dout", dout, 16'h0000);
        check("rst.vld",  dout_vld, 1'b0);
        check("rst.done", done, 1'b0);
        check_status("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single pass of four fixed words, strobes three cycles apart
        for (int i = 1; i <= 4; i++) load(16'(i * 16'h1111), 1'b0, "t1.load");
        do_start(1'b0, "t1.start");
        for (int i = 0; i < 6; i++) begin
            play_cycle(1'b1, 1'b0, "t1.strobe");
            play_cycle(1'b0, 1'b0, "t1.gap");
            play_cycle(1'b0, 1'b0, "t1.gap");
        end

        // Three words looped at full strobe rate; clear rides with a write
        load(16'hBEEF, 1'b1, "t2.clr");
        for (int i = 0; i < 3; i++) load(16'($urandom), 1'b0, "t2.load");
        loop_en = 1'b1;
        do_start(1'b0, "t2.start");
        for (int i = 0; i < 10; i++) play_cycle(1'b1, 1'b0, "t2.play");
        play_cycle(1'b0, 1'b1, "t2.stop");
        loop_en = 1'b0;

        // Fill to full depth plus one dropped word, then loop across the wrap
        load(16'h0, 1'b1, "t3.clr");
        for (int i = 0; i < DEPTH + 1; i++) load(16'($urandom), 1'b0, "t3.load");
        loop_en = 1'b1;
        do_start(1'b0, "t3.start");
        for (int i = 0; i < DEPTH + 1; i++) play_cycle(1'b1, 1'b0, "t3.play");
        play_cycle(1'b0, 1'b1, "t3.stop");
        loop_en = 1'b0;

        // Start on an empty buffer, then start together with stop
        load(16'h0, 1'b1, "t4.clr");
        do_start(1'b0, "t4.empty_start");
        load(16'($urandom), 1'b0, "t4.load");
        load(16'($urandom), 1'b0, "t4.load");
        do_start(1'b1, "t4.start_stop");

        // Stop together with a strobe in mid-run
        load(16'h0, 1'b1, "t5.clr");
        for (int i = 0; i < 5; i++) load(16'($urandom), 1'b0, "t5.load");
        do_start(1'b0, "t5.start");
        play_cycle(1'b1, 1'b0, "t5.play");
        play_cycle(1'b1, 1'b0, "t5.play");
        play_cycle(1'b1, 1'b1, "t5.stop");
        for (int i = 0; i < 3; i++) play_cycle(1'b1, 1'b0, "t5.after");

        // Asynchronous reset between clock edges during a looping run
        load(16'h0, 1'b1, "t6.clr");
        for (int i = 0; i < 4; i++) load(16'($urandom), 1'b0, "t6.load");
        loop_en = 1'b1;
        do_start(1'b0, "t6.start");
        play_cycle(1'b1, 1'b0, "t6.play");
        play_cycle(1'b1, 1'b0, "t6.play");
        #2;
        rst_n = 1'b0;
        #1;
        mdl_buf.delete();
        mdl_run  = 1'b0;
        mdl_loop = 1'b0;
        mdl_k    = 0;
        mdl_n    = 0;
        mdl_dout = '0;
        check("t6.rst.dout", dout, 16'h0000);
        check("t6.rst.vld",  dout_vld, 1'b0);
        check("t6.rst.done", done, 1'b0);
        check_status("t6.rst");
        loop_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reload after reset; a write during the run must be dropped
        load(16'($urandom), 1'b0, "t6.reload");
        load(16'($urandom), 1'b0, "t6.reload");
        do_start(1'b0, "t6.restart");
        load(16'($urandom), 1'b0, "t6.run_write");
        for (int i = 0; i < 3; i++) play_cycle(1'b1, 1'b0, "t6.replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
